// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;
    localparam int          XLEN_DEF         = 32;
    localparam int          ILEN_DEF         = 32;
    localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
    localparam int          INSTR_BYTES      = 4;

    // One buffered fetch: the address it came from and the instruction word.
    typedef struct packed {
        logic [XLEN_DEF-1:0] pc;
        logic [ILEN_DEF-1:0] instr;
    } ibuf_entry_t;
endpackage

// File: rtl/fetch_ibuf.sv
// Small synchronous FIFO between fetch and decode. The extra count register
// tells full from empty, since the pointers wrap naturally.
module fetch_ibuf
    import fetch_pkg::*;
#(
    parameter type entry_t = ibuf_entry_t,
    parameter int  DEPTH   = 2,
    localparam int AW      = $clog2(DEPTH),
    localparam int CW      = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  entry_t        wdata,
    output entry_t        head,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);
    entry_t        mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;

    // Storage, pointers and occupancy; flush drops everything, including a same-cycle pop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[wptr] <= wdata;
                wptr      <= wptr + AW'(1);
            end
            if (pop) rptr <= rptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign head  = mem[rptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC register, next-PC selection, cache request
// gating and the decode-side instruction buffer.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (sticky misaligned-redirect trap).
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int             XLEN         = XLEN_DEF,
    parameter int             ILEN         = ILEN_DEF,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEF),
    parameter int             IBUF_DEPTH   = 2,
    localparam int            CW           = $clog2(IBUF_DEPTH) + 1
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [ILEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    output logic            dec_valid,
    input  logic            dec_ready,
    output logic [ILEN-1:0] dec_instr,
    output logic [XLEN-1:0] dec_pc,
    output logic [XLEN-1:0] dec_pc_plus4,
`ifdef FETCH_MISALIGN_TRAP_EN
    output logic            misalign_trap,
`endif
    output logic [CW-1:0]   ibuf_count
);
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } entry_t;

    logic [XLEN-1:0] pc;
    logic            run;
    logic            push;
    logic            pop;
    logic            flush;
    logic            full;
    logic            empty;
    logic            halt;
    logic            misaligned;
    logic [XLEN-1:0] redirect_pc;
    entry_t          wdata;
    entry_t          head;

    // Low address bits are dropped so the PC always stays word aligned.
    assign redirect_pc = redirect_target & ~XLEN'(INSTR_BYTES - 1);

`ifdef FETCH_MISALIGN_TRAP_EN
    logic trap_q;
    assign misaligned = redirect_valid & (|redirect_target[1:0]);

    // Sticky trap: once a misaligned target is seen, fetch stays frozen until reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) trap_q <= 1'b0;
        else        trap_q <= trap_q | misaligned;
    end

    assign halt          = trap_q;
    assign misalign_trap = trap_q;
`else
    assign misaligned = 1'b0;
    assign halt       = 1'b0;
`endif

    // Fetching starts on the first clock edge after reset is released.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) run <= 1'b0;
        else        run <= 1'b1;
    end

    assign pop      = dec_valid & dec_ready;
    assign imem_req = run & ~redirect_valid & ~halt & (~full | pop);
    assign push     = imem_req & imem_ready;
    assign flush    = redirect_valid | halt;
    assign imem_addr = pc;

    // PC: redirect beats sequential advance; a stall simply holds.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc <= RESET_VECTOR;
        end else if (halt) begin
            pc <= pc;
        end else if (redirect_valid) begin
            if (!misaligned) pc <= redirect_pc;
        end else if (push) begin
            pc <= pc + XLEN'(INSTR_BYTES);
        end
    end

    assign wdata.pc    = pc;
    assign wdata.instr = imem_rdata;

    fetch_ibuf #(
        .entry_t (entry_t),
        .DEPTH   (IBUF_DEPTH)
    ) u_ibuf (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .wdata (wdata),
        .head  (head),
        .count (ibuf_count),
        .full  (full),
        .empty (empty)
    );

    // Head fields are zeroed while the buffer is empty so decode never sees stale data.
    assign dec_valid    = ~empty & ~halt;
    assign dec_pc       = dec_valid ? head.pc : '0;
    assign dec_instr    = dec_valid ? head.instr : '0;
    assign dec_pc_plus4 = dec_valid ? head.pc + XLEN'(INSTR_BYTES) : '0;
endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a reference model predicts request gating
// and queues every expected fetch, which is popped when decode accepts it.
module tb_fetch_unit;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = '0;
    logic        dec_ready = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        dec_valid;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic [31:0] dec_pc_plus4;
    logic [1:0]  ibuf_count;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        misalign_trap;
    logic        w_trap;
`endif

    // Second instance free-runs from a reset vector near the top of memory.
    logic        w_req, w_valid;
    logic [31:0] w_addr, w_instr, w_pc, w_pc4;
    logic [1:0]  w_count;

    always #5 clk = ~clk;

    fetch_unit #(.IBUF_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_instr(dec_instr), .dec_pc(dec_pc), .dec_pc_plus4(dec_pc_plus4),
`ifdef FETCH_MISALIGN_TRAP_EN
        .misalign_trap(misalign_trap),
`endif
        .ibuf_count(ibuf_count)
    );

    fetch_unit #(.RESET_VECTOR(32'hFFFF_FFF8), .IBUF_DEPTH(DEPTH)) dut_wrap (
        .clk(clk), .reset(reset),
        .imem_req(w_req), .imem_addr(w_addr),
        .imem_ready(1'b1), .imem_rdata(32'h0000_0013),
        .redirect_valid(1'b0), .redirect_target(32'h0),
        .dec_valid(w_valid), .dec_ready(1'b1),
        .dec_instr(w_instr), .dec_pc(w_pc), .dec_pc_plus4(w_pc4),
`ifdef FETCH_MISALIGN_TRAP_EN
        .misalign_trap(w_trap),
`endif
        .ibuf_count(w_count)
    );

    int errors = 0;
    int checks = 0;

    logic [63:0] mq[$];
    logic [31:0] mpc;
    bit          mrun;
    int          cyc;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    // One cycle: drive inputs, compare against the model, advance the model, clock.
    task automatic step(input bit rdy, input bit drdy, input bit rv, input logic [31:0] rt);
        logic [63:0] e;
        bit          mpop, mreq;
        int          n;
        imem_ready      = rdy;
        dec_ready       = drdy;
        redirect_valid  = rv;
        redirect_target = rt;
        imem_rdata      = instr_of(mpc);
        #1;
        n    = mq.size();
        mpop = (n != 0) && drdy;
        mreq = mrun && !rv && (n < DEPTH || mpop);
        chk("imem_req", 64'(imem_req), 64'(mreq));
        chk("imem_addr", 64'(imem_addr), 64'(mpc));
        chk("dec_valid", 64'(dec_valid), 64'(n != 0));
        chk("ibuf_count", 64'(ibuf_count), 64'(n));
        if (n != 0) begin
            e = mq[0];
            chk("dec_pc", 64'(dec_pc), 64'(e[63:32]));
            chk("dec_instr", 64'(dec_instr), 64'(e[31:0]));
            chk("dec_pc_plus4", 64'(dec_pc_plus4), 64'(e[63:32] + 32'd4));
        end
        case (cyc)
            0: begin
                chk("wrap_addr0", 64'(w_addr), 64'h0000_0000_FFFF_FFF8);
                chk("wrap_req0", 64'(w_req), 64'h0);
            end
            1: begin
                chk("wrap_addr1", 64'(w_addr), 64'h0000_0000_FFFF_FFF8);
                chk("wrap_req1", 64'(w_req), 64'h1);
            end
            2: begin
                chk("wrap_addr2", 64'(w_addr), 64'h0000_0000_FFFF_FFFC);
                chk("wrap_pc2", 64'(w_pc), 64'h0000_0000_FFFF_FFF8);
                chk("wrap_pc4_2", 64'(w_pc4), 64'h0000_0000_FFFF_FFFC);
            end
            3: begin
                chk("wrap_addr3", 64'(w_addr), 64'h0);
                chk("wrap_pc3", 64'(w_pc), 64'h0000_0000_FFFF_FFFC);
                chk("wrap_pc4_3", 64'(w_pc4), 64'h0);
            end
            default: ;
        endcase
        if (rv) begin
            mq.delete();
            mpc = rt & ~32'd3;
        end else begin
            if (mpop) e = mq.pop_front();
            if (mreq && rdy) begin
                mq.push_back({mpc, instr_of(mpc)});
                mpc = mpc + 32'd4;
            end
        end
        @(posedge clk);
        mrun = 1'b1;
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        mpc  = 32'h0;
        mrun = 1'b0;
        cyc  = 0;
        // Reset state
        #3;
        chk("rst_req", 64'(imem_req), 64'h0);
        chk("rst_addr", 64'(imem_addr), 64'h0);
        chk("rst_valid", 64'(dec_valid), 64'h0);
        chk("rst_count", 64'(ibuf_count), 64'h0);
        chk("rst_pc", 64'(dec_pc), 64'h0);
        chk("rst_instr", 64'(dec_instr), 64'h0);
        chk("rst_pc4", 64'(dec_pc_plus4), 64'h0);
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("rst_trap", 64'(misalign_trap), 64'h0);
`endif
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Free run: one in flight, occupancy 1
        repeat (6) step(1, 1, 0, 0);
        // Drain to empty, then hold decode off until the buffer fills
        step(0, 1, 0, 0);
        repeat (5) step(1, 0, 0, 0);
        chk("fill_count", 64'(ibuf_count), 64'(DEPTH));
        chk("fill_req", 64'(imem_req), 64'h0);
        repeat (4) step(1, 1, 0, 0);
        // Cache stall: PC holds while the buffer drains
        repeat (3) step(0, 1, 0, 0);
        repeat (3) step(1, 1, 0, 0);
        // Redirect while full with the cache ready
        repeat (2) step(1, 0, 0, 0);
        chk("pre_redir_count", 64'(ibuf_count), 64'(DEPTH));
        step(1, 1, 1, 32'h0000_0100);
        chk("redir_addr", 64'(imem_addr), 64'h100);
        chk("redir_valid", 64'(dec_valid), 64'h0);
        repeat (3) step(1, 1, 0, 0);
        // Random mix of stalls, back-pressure and aligned redirects
        for (int i = 0; i < 60; i++)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 9) == 0, 32'($urandom_range(0, 1023)) << 2);

        // Misaligned redirect
`ifdef FETCH_MISALIGN_TRAP_EN
        imem_ready = 1'b1; dec_ready = 1'b1;
        redirect_valid = 1'b1; redirect_target = 32'h0000_0102;
        #1;
        chk("trap_before", 64'(misalign_trap), 64'h0);
        @(negedge clk);
        redirect_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("trap_set", 64'(misalign_trap), 64'h1);
            chk("trap_req", 64'(imem_req), 64'h0);
            chk("trap_valid", 64'(dec_valid), 64'h0);
            @(negedge clk);
        end
`else
        step(1, 1, 1, 32'h0000_0102);
        chk("misalign_addr", 64'(imem_addr), 64'h100);
        repeat (3) step(1, 1, 0, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Parametrised instruction-fetch front end that replaces the flat PC register/adder/mux arrangement of the single-cycle datapath.
- Owns the PC and issues sequential fetches to the instruction cache.
- Honours the cache stall and accepts branch/JALR redirects.
- Buffers fetched instructions in a small FIFO with a valid/ready handshake toward decode, so the core can move to a decoupled or pipelined organisation.

Parameters:
- XLEN, 32, PC/instruction-address and data width
- ILEN, 32, instruction width (bits [ILEN-1:0] of the cache word)
- RESET_VECTOR, 32'h0000_0000, PC value after reset
- IBUF_DEPTH, 2, instruction-buffer entries (power of two, ≥2)

Ports:
- clk  in  1  clock; rising edge
- reset  in  1  asynchronous, active-low reset
- imem_req  out  1  fetch request valid
- imem_addr  out  XLEN  fetch address (= PC)
- imem_ready  in  1  cache hit/ready; imem_rdata valid for imem_addr this cycle; low = stall
- imem_rdata  in  ILEN  fetched instruction
- redirect_valid  in  1  taken branch/jump this cycle
- redirect_target  in  XLEN  new PC (target adder / JALR result)
- dec_valid  out  1  buffer head valid
- dec_ready  in  1  decode accepts head
- dec_instr  out  ILEN  head instruction
- dec_pc  out  XLEN  head PC
- dec_pc_plus4  out  XLEN  head PC + 4, for JAL/JALR link write-back
- ibuf_count  out  $clog2(IBUF_DEPTH)+1  occupancy

Behaviour:
- Reset (async, on reset=0): pc=RESET_VECTOR, FIFO empty, pointers 0, dec_valid=0, ibuf_count=0, dec_* outputs 0. Release is synchronous to the next clk edge.
- imem_req = reset_released & ~redirect_valid & (~full | pop).
- imem_addr = pc at all times, combinational from the register.
- push = imem_req & imem_ready.
  - On push, {pc, imem_rdata} is written at the write pointer, and pc <= pc+4.
  - PC arithmetic is modulo 2^XLEN; wrap from all-ones-minus-3 to 0 is legal.
- pop = dec_valid & dec_ready; it advances the read pointer.
- Fetch-to-decode latency: 1 cycle. An instruction pushed at edge N is visible on dec_* after edge N.
- Stall (imem_ready=0): pc holds, no push; the FIFO still drains via pop.
- Full:
  - Push is allowed only if pop occurs in the same cycle.
  - Push+pop together leaves the count unchanged.
  - Pop on empty is impossible because dec_valid=0.
- Redirect has top priority:
  - Flush the FIFO (count <= 0, pointers reset, dec_valid=0 next cycle).
  - pc <= redirect_target.
  - Suppress push that cycle, even if imem_ready=1.
  - A same-cycle pop is discarded; the consumer must not rely on it.
- Pointers are $clog2(IBUF_DEPTH) bits and wrap naturally; an extra count register disambiguates full/empty.
- dec_* reflect the head entry combinationally from FIFO storage. dec_pc_plus4 = dec_pc + 4, modulo 2^XLEN.
- Reset mid-stall or mid-redirect: the async reset wins immediately; no pending state survives.

Optional Feature:
- Macro: FETCH_MISALIGN_TRAP_EN.
- When defined:
  - Adds output port misalign_trap (1 bit, reset 0).
  - A redirect with redirect_target[1:0]!=0 sets misalign_trap, which stays sticky until reset.
  - While misalign_trap=1: pc is not updated, imem_req=0, the FIFO is flushed, and dec_valid=0.
- When undefined:
  - No port.
  - redirect_target[1:0] are ignored and forced to 00 when loading pc.

Decomposition:
- Package fetch_pkg holds:
  - XLEN/ILEN defaults and RESET_VECTOR default
  - typedef ibuf_entry_t {pc, instr}
  - localparam INSTR_BYTES=4
- Sub-module fetch_ibuf: the parametrised synchronous FIFO of ibuf_entry_t.
  - Inputs: push, pop, flush. Outputs: head, count, full, empty.
  - Async active-low reset.
- fetch_unit contains the PC register, next-PC logic, request gating and the optional trap.

Test Plan:
- Reset release, imem_ready=1, dec_ready=1, rdata=addr-derived → imem_addr 0,4,8,…; dec_pc 0,4,8 one cycle later; ibuf_count stays 1.
- dec_ready=0 for 5 cycles from empty → exactly IBUF_DEPTH(2) pushes, then imem_req=0, pc=8, count=2. dec_ready=1 then drains in order 0,4 and fetch resumes at 8.
- imem_ready=0 for 3 cycles at pc=0x10 → imem_addr held 0x10, no push, buffered entries still pop. Ready returns → 0x10 fetched once, no duplicate.
- redirect_valid with target 0x100 while count=2 and imem_ready=1 → next cycle count=0, dec_valid=0, imem_addr=0x100. Following cycle dec_pc=0x100.
- RESET_VECTOR=32'hFFFF_FFF8, free-run → PCs FFFF_FFF8, FFFF_FFFC, 0000_0000. dec_pc_plus4 for FFFF_FFFC is 0.
- With FETCH_MISALIGN_TRAP_EN, redirect target 0x102 → misalign_trap=1, imem_req=0 and dec_valid=0 until reset. Without the macro → pc loads 0x100.
